// File: rtl/x_respawn_if.sv
// Load-x bus between the respawn scheduler (master) and the game FSM /
// coordinate register bank (slave). The scheduler drives the load strobe,
// the column index and its status outputs. The game side drives the
// respawn requests and the grant enable.
interface x_respawn_if #(
  parameter int N_OBJ  = 10,
  parameter int RAND_W = 4
);
  logic              enable;
  logic [N_OBJ-1:0]  respawn_req;
  logic [N_OBJ-1:0]  load_x;
  logic [RAND_W-1:0] rand_int;
  logic [N_OBJ-1:0]  pending;
  logic              busy;

  modport master (
    input  enable, respawn_req,
    output load_x, rand_int, pending, busy
  );

  modport slave (
    output enable, respawn_req,
    input  load_x, rand_int, pending, busy
  );
endinterface

// File: rtl/x_respawn_scheduler.sv
// Respawn scheduler: latches per-lane respawn requests and picks one lane
// at a time in round-robin order. For each chosen lane it draws a column
// index from an 8-bit LFSR and pulses a one-hot load_x strobe with a stable
// rand_int. A candidate above MAX_RAND is rejected, and so is a candidate
// equal to the previous grant's index. Each rejection retries one cycle
// later with the next LFSR value.
module x_respawn_scheduler #(
  parameter int         N_OBJ       = 10,
  parameter int         RAND_W      = 4,
  parameter int         MAX_RAND    = 14,
  parameter int         HOLD_CYCLES = 1,
  parameter logic [7:0] SEED        = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  x_respawn_if.master bus
);

  localparam int PTR_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t            state_r;
  logic [7:0]        lfsr_r;
  logic [PTR_W-1:0]  ptr_r;
  logic [PTR_W-1:0]  sel_r;
  logic [RAND_W-1:0] last_rand_r;
  logic [1:0]        hold_cnt_r;

  logic [PTR_W-1:0]  scan_s;
  logic [PTR_W-1:0]  idx_s;
  logic              found_s;
  logic [RAND_W-1:0] cand_s;
  logic              cand_ok_s;
  logic              last_hold_s;
  logic [N_OBJ-1:0]  clr_s;

  // Feedback bit for x^8 + x^6 + x^5 + x^4 + 1 (maximal length, 255 states).
  function automatic logic lfsr_fb(input logic [7:0] v);
    return v[7] ^ v[5] ^ v[4] ^ v[3];
  endfunction

  // One-hot lane mask for a lane index.
  function automatic logic [N_OBJ-1:0] lane_mask(input logic [PTR_W-1:0] i);
    logic [N_OBJ-1:0] m;
    m = {N_OBJ{1'b0}};
    for (int k = 0; k < N_OBJ; k++) begin
      m[k] = (PTR_W'(k) == i);
    end
    return m;
  endfunction

  // Round-robin search: first pending lane at or above the pointer, wrapping.
  always_comb begin
    idx_s   = {PTR_W{1'b0}};
    found_s = 1'b0;
    scan_s  = {PTR_W{1'b0}};
    for (int i = 0; i < N_OBJ; i++) begin
      scan_s = PTR_W'((int'(ptr_r) + i) % N_OBJ);
      if (!found_s && bus.pending[scan_s]) begin
        idx_s   = scan_s;
        found_s = 1'b1;
      end else begin
        idx_s   = idx_s;
      end
    end
  end

  // Candidate screening and the pending-clear mask for the final ISSUE cycle.
  always_comb begin
    cand_s      = lfsr_r[RAND_W-1:0];
    cand_ok_s   = found_s && (cand_s <= RAND_W'(MAX_RAND)) && (cand_s != last_rand_r);
    last_hold_s = (hold_cnt_r == 2'(HOLD_CYCLES - 1));
    if ((state_r == ISSUE) && last_hold_s) begin
      clr_s = lane_mask(sel_r);
    end else begin
      clr_s = {N_OBJ{1'b0}};
    end
  end

  // LFSR, pending bookkeeping and the IDLE/ARB/ISSUE grant FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      lfsr_r       <= SEED;
      ptr_r        <= {PTR_W{1'b0}};
      sel_r        <= {PTR_W{1'b0}};
      last_rand_r  <= {RAND_W{1'b1}};
      hold_cnt_r   <= 2'd0;
      bus.load_x   <= {N_OBJ{1'b0}};
      bus.rand_int <= {RAND_W{1'b0}};
      bus.pending  <= {N_OBJ{1'b0}};
      bus.busy     <= 1'b0;
    end else begin
      lfsr_r      <= {lfsr_r[6:0], lfsr_fb(lfsr_r)};
      // A new request for a lane outranks that lane's clear in the same cycle.
      bus.pending <= (bus.pending & ~clr_s) | bus.respawn_req;
      case (state_r)
        IDLE: begin
          if (bus.enable && (|bus.pending)) begin
            state_r  <= ARB;
            bus.busy <= 1'b1;
          end else begin
            bus.busy <= 1'b0;
          end
        end
        ARB: begin
          // enable is not sampled here: once arbitration starts it finishes.
          if (cand_ok_s) begin
            bus.rand_int <= cand_s;
            sel_r        <= idx_s;
            hold_cnt_r   <= 2'd0;
            bus.load_x   <= lane_mask(idx_s);
            state_r      <= ISSUE;
          end else begin
            state_r      <= ARB;
          end
        end
        ISSUE: begin
          if (last_hold_s) begin
            bus.load_x  <= {N_OBJ{1'b0}};
            last_rand_r <= bus.rand_int;
            ptr_r       <= (sel_r == PTR_W'(N_OBJ - 1)) ? {PTR_W{1'b0}} : sel_r + 1'b1;
            state_r     <= IDLE;
            bus.busy    <= 1'b0;
          end else begin
            hold_cnt_r  <= hold_cnt_r + 2'd1;
          end
        end
        default: begin
          state_r    <= IDLE;
          bus.load_x <= {N_OBJ{1'b0}};
          bus.busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x_respawn_scheduler.sv
// Directed bench for x_respawn_scheduler. dut1 uses HOLD_CYCLES=1 and runs
// through a per-cycle monitor that pops expected lanes from a scoreboard
// queue. dut2 uses HOLD_CYCLES=2 and covers the case where a new request
// for a lane arrives in the same cycle that lane's pending bit is cleared.
module tb_x_respawn_scheduler;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  x_respawn_if #(.N_OBJ(10), .RAND_W(4)) bus1 ();
  x_respawn_if #(.N_OBJ(10), .RAND_W(4)) bus2 ();

  x_respawn_scheduler #(
    .N_OBJ(10), .RAND_W(4), .MAX_RAND(14), .HOLD_CYCLES(1), .SEED(8'hA5)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.master)
  );

  x_respawn_scheduler #(
    .N_OBJ(10), .RAND_W(4), .MAX_RAND(14), .HOLD_CYCLES(2), .SEED(8'hA5)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.master)
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  int          cycle = 0;
  int          exp_q[$];
  int          req_cycle[10];
  logic [9:0]  prev_load;
  int          hold_run;
  logic [3:0]  exp_rand;
  logic [3:0]  grant_rand;
  bit          have_last;
  int          last_high;
  logic [3:0]  r1;
  int          n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    prev_load = 10'd0;
    hold_run  = 0;
    exp_rand  = 4'd0;
    have_last = 1'b0;
    last_high = -100;
  endtask

  task automatic push_req(input int lane);
    exp_q.push_back(lane);
    req_cycle[lane] = cycle;
  endtask

  // Advance one clock, then check dut1 against the scoreboard.
  task automatic cyc();
    int lane;
    @(posedge clk);
    #1;
    cycle++;
    check("onehot", 32'($onehot0(bus1.load_x)), 32'd1);
    if (bus1.load_x != 10'd0) begin
      if (prev_load == 10'd0) begin
        hold_run = 1;
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(bus1.load_x), 32'd0);
        end else begin
          lane = exp_q.pop_front();
          check("grant_lane", 32'(bus1.load_x), 32'd1 << lane);
          check("latency_min", 32'((cycle - req_cycle[lane]) >= 3), 32'd1);
        end
        check("rand_max", 32'(bus1.rand_int <= 4'd14), 32'd1);
        if (have_last) check("rand_repeat", 32'(bus1.rand_int != grant_rand), 32'd1);
        check("grant_gap", 32'((cycle - last_high) >= 3), 32'd1);
        grant_rand = bus1.rand_int;
        exp_rand   = bus1.rand_int;
        have_last  = 1'b1;
      end else begin
        hold_run++;
        check("rand_stable", 32'(bus1.rand_int), 32'(exp_rand));
      end
      last_high = cycle;
    end else begin
      if (prev_load != 10'd0) check("hold_len", 32'(hold_run), 32'd1);
      check("rand_hold", 32'(bus1.rand_int), 32'(exp_rand));
    end
    prev_load = bus1.load_x;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      cyc();
      k++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset             = 1'b1;
    bus1.enable       = 1'b1;
    bus1.respawn_req  = 10'd0;
    bus2.enable       = 1'b1;
    bus2.respawn_req  = 10'd0;
    model_reset();

    // Reset then idle.
    cyc();
    cyc();
    check("reset_lfsr", 32'(dut1.lfsr_r), 32'h0A5);
    check("reset_load", 32'(bus1.load_x), 32'd0);
    check("reset_pending", 32'(bus1.pending), 32'd0);
    check("reset_busy", 32'(bus1.busy), 32'd0);
    check("reset_rand", 32'(bus1.rand_int), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("idle_load", 32'(bus1.load_x), 32'd0);
      check("idle_pending", 32'(bus1.pending), 32'd0);
      check("idle_busy", 32'(bus1.busy), 32'd0);
    end

    // Single request on lane 3.
    bus1.respawn_req = 10'b0000001000;
    push_req(3);
    cyc();
    bus1.respawn_req = 10'd0;
    check("single_pending", 32'(bus1.pending), 32'h008);
    drain(400);
    cyc();
    check("single_clear", 32'(bus1.pending), 32'd0);
    check("single_busy", 32'(bus1.busy), 32'd0);

    // Round-robin from pointer 0: lanes 0, 1, 9.
    reset = 1'b1;
    model_reset();
    cyc();
    cyc();
    reset = 1'b0;
    bus1.respawn_req = 10'b1000000011;
    push_req(0);
    push_req(1);
    push_req(9);
    cyc();
    bus1.respawn_req = 10'd0;
    check("rr_pending", 32'(bus1.pending), 32'h203);
    drain(1200);
    repeat (3) cyc();
    check("rr_clear", 32'(bus1.pending), 32'd0);

    // enable gating: requests accumulate, grants wait for enable.
    bus1.enable      = 1'b0;
    bus1.respawn_req = 10'b0010000100;
    push_req(2);
    push_req(7);
    cyc();
    bus1.respawn_req = 10'd0;
    repeat (5) cyc();
    check("gate_pending", 32'(bus1.pending), 32'h084);
    check("gate_load", 32'(bus1.load_x), 32'd0);
    check("gate_busy", 32'(bus1.busy), 32'd0);
    bus1.enable = 1'b1;
    drain(1000);
    repeat (3) cyc();
    check("gate_clear", 32'(bus1.pending), 32'd0);

    // Set beats clear on dut2 (two-cycle hold).
    bus2.respawn_req = 10'b0000100000;
    cyc();
    bus2.respawn_req = 10'd0;
    check("sbc_pending", 32'(bus2.pending), 32'h020);
    n = 0;
    while (bus2.load_x == 10'd0 && n < 600) begin
      cyc();
      n++;
    end
    check("sbc_grant1_c0", 32'(bus2.load_x), 32'h020);
    r1 = bus2.rand_int;
    check("sbc_rand_max", 32'(r1 <= 4'd14), 32'd1);
    cyc();
    check("sbc_grant1_c1", 32'(bus2.load_x), 32'h020);
    check("sbc_rand_stable", 32'(bus2.rand_int), 32'(r1));
    bus2.respawn_req = 10'b0000100000;
    cyc();
    bus2.respawn_req = 10'd0;
    check("sbc_load_off", 32'(bus2.load_x), 32'd0);
    check("sbc_still_pending", 32'(bus2.pending), 32'h020);
    n = 0;
    while (bus2.load_x == 10'd0 && n < 600) begin
      cyc();
      n++;
    end
    check("sbc_grant2_c0", 32'(bus2.load_x), 32'h020);
    check("sbc_rand_differs", 32'(bus2.rand_int != r1), 32'd1);
    cyc();
    check("sbc_grant2_c1", 32'(bus2.load_x), 32'h020);
    cyc();
    check("sbc_end_load", 32'(bus2.load_x), 32'd0);
    check("sbc_end_pending", 32'(bus2.pending), 32'd0);

    // Reset while dut1 is issuing lane 4 with lane 6 still pending.
    bus1.respawn_req = 10'b0001010000;
    push_req(4);
    push_req(6);
    cyc();
    bus1.respawn_req = 10'd0;
    n = 0;
    while (bus1.load_x == 10'd0 && n < 600) begin
      cyc();
      n++;
    end
    check("mid_grant", 32'(bus1.load_x), 32'h010);
    reset = 1'b1;
    model_reset();
    cyc();
    check("mid_load", 32'(bus1.load_x), 32'd0);
    check("mid_pending", 32'(bus1.pending), 32'd0);
    check("mid_busy", 32'(bus1.busy), 32'd0);
    check("mid_rand", 32'(bus1.rand_int), 32'd0);
    reset = 1'b0;
    repeat (3) cyc();
    check("post_pending", 32'(bus1.pending), 32'd0);
    check("post_busy", 32'(bus1.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
